// File: rtl/maj_net_sequencer.sv
// maj_net_sequencer: runtime-programmable majority-of-three network evaluator.
// One shared MAJ3 unit walks the gate program one gate per cycle; gate outputs
// land in g_q and the selected output node is registered when evaluation ends.
`timescale 1ns/1ps
module maj_net_sequencer #(
   parameter int MAX_GATES = 16,
   parameter int SEL_W     = 5,
   parameter int GA_W      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we_i,
   input  logic [GA_W-1:0]           cfg_addr_i,
   input  logic [3*(SEL_W+1)-1:0]    cfg_data_i,
   input  logic [GA_W:0]             cfg_num_i,
   input  logic [SEL_W-1:0]          cfg_out_sel_i,
   input  logic                      cfg_out_inv_i,
   output logic                      cfg_ready_o,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [6:0]                x_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_o,
   output logic                      err_o
);

   localparam int OP_W  = SEL_W + 1;
   localparam int ENT_W = 3 * OP_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ENT_W-1:0]     prog_q [MAX_GATES];
   logic [MAX_GATES-1:0] g_q, g_d;
   logic [6:0]           x_q, x_d;
   logic [GA_W:0]        num_q, num_d;
   logic [SEL_W-1:0]     osel_q, osel_d;
   logic                 oinv_q, oinv_d;
   logic [GA_W-1:0]      k_q, k_d;
   logic                 eacc_q, eacc_d;
   logic                 out_q, out_d;
   logic                 err_q, err_d;

   logic                 accept_s;
   logic                 last_s;
   logic [GA_W:0]        num_sat_s;
   logic [ENT_W-1:0]     entry_s;
   logic                 a_s, b_s, c_s, gate_s, op_err_s;

   // Value of a node: const0, an input bit, or a gate register; unmapped reads 0.
   function automatic logic node_val(input logic [SEL_W-1:0] sel,
                                     input logic [6:0] xv,
                                     input logic [MAX_GATES-1:0] gv);
      logic v;
      v = 1'b0;
      for (int i = 0; i < 7; i++) begin
         v = (int'(sel) == i + 1) ? xv[i] : v;
      end
      for (int j = 0; j < MAX_GATES; j++) begin
         v = (int'(sel) == j + 8) ? gv[j] : v;
      end
      return v;
   endfunction

   // A selector at or beyond gate node 8+lim is a forward/self or illegal reference.
   function automatic logic beyond(input logic [SEL_W-1:0] sel, input int lim);
      return (int'(sel) >= 8 + lim);
   endfunction

   assign accept_s  = in_valid_i && (state_q == ST_IDLE);
   assign num_sat_s = (cfg_num_i > (GA_W+1)'(MAX_GATES)) ? (GA_W+1)'(MAX_GATES) : cfg_num_i;
   assign last_s    = ({1'b0, k_q} == (num_q - (GA_W+1)'(1)));
   assign entry_s   = prog_q[k_q];
   assign out_o     = out_q;
   assign err_o     = err_q;

   // Gate program store: writable only while idle, intentionally not reset.
   always_ff @(posedge clk) begin
      if (cfg_we_i && (state_q == ST_IDLE)) begin
         prog_q[cfg_addr_i] <= cfg_data_i;
      end
   end

   // Shared MAJ3 unit fed by the current gate's three (possibly inverted) operands.
   always_comb begin
      a_s      = node_val(entry_s[3*OP_W-2 -: SEL_W], x_q, g_q) ^ entry_s[3*OP_W-1];
      b_s      = node_val(entry_s[2*OP_W-2 -: SEL_W], x_q, g_q) ^ entry_s[2*OP_W-1];
      c_s      = node_val(entry_s[OP_W-2 -: SEL_W], x_q, g_q) ^ entry_s[OP_W-1];
      gate_s   = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);
      op_err_s = beyond(entry_s[3*OP_W-2 -: SEL_W], int'(k_q)) |
                 beyond(entry_s[2*OP_W-2 -: SEL_W], int'(k_q)) |
                 beyond(entry_s[OP_W-2 -: SEL_W], int'(k_q));
   end

   // Datapath next state: capture on accept, evaluate one gate per EVAL cycle.
   always_comb begin
      x_d    = x_q;
      num_d  = num_q;
      osel_d = osel_q;
      oinv_d = oinv_q;
      k_d    = k_q;
      g_d    = g_q;
      eacc_d = eacc_q;
      out_d  = out_q;
      err_d  = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               x_d    = x_i;
               num_d  = num_sat_s;
               osel_d = cfg_out_sel_i;
               oinv_d = cfg_out_inv_i;
               k_d    = '0;
               g_d    = '0;
               eacc_d = 1'b0;
               err_d  = 1'b0;
               if (num_sat_s == '0) begin
                  // No gates: the output reads an input node directly.
                  out_d = (beyond(cfg_out_sel_i, 0) ? 1'b0
                           : node_val(cfg_out_sel_i, x_i, '0)) ^ cfg_out_inv_i;
                  err_d = beyond(cfg_out_sel_i, 0);
               end else begin
                  out_d = out_q;
               end
            end else begin
               x_d = x_q;
            end
         end
         ST_EVAL: begin
            g_d[k_q] = gate_s;
            eacc_d   = eacc_q | op_err_s;
            k_d      = k_q + GA_W'(1);
            if (last_s) begin
               // Output node may be the gate just computed, so read from g_d.
               out_d = (beyond(osel_q, int'(num_q)) ? 1'b0
                        : node_val(osel_q, x_q, g_d)) ^ oinv_q;
               err_d = eacc_q | op_err_s | beyond(osel_q, int'(num_q));
            end else begin
               out_d = out_q;
            end
         end
         ST_DONE: begin
            out_d = out_q;
         end
         default: begin
            out_d = out_q;
         end
      endcase
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = (num_sat_s == '0) ? ST_DONE : ST_EVAL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_EVAL;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output decode: handshake signals follow the state register.
   always_comb begin
      cfg_ready_o = 1'b0;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cfg_ready_o = 1'b1;
            in_ready_o  = 1'b1;
         end
         ST_DONE: out_valid_o = 1'b1;
         default: out_valid_o = 1'b0;
      endcase
   end

   // State and datapath registers; reset aborts any evaluation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         num_q   <= '0;
         osel_q  <= '0;
         oinv_q  <= 1'b0;
         k_q     <= '0;
         g_q     <= '0;
         eacc_q  <= 1'b0;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         num_q   <= num_d;
         osel_q  <= osel_d;
         oinv_q  <= oinv_d;
         k_q     <= k_d;
         g_q     <= g_d;
         eacc_q  <= eacc_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Bench for maj_net_sequencer: directed steps plus randomized programs, each
// result compared with a truth-level network model held in the bench.
`timescale 1ns/1ps
module tb_maj_net_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [17:0] cfg_data;
   logic [4:0]  cfg_num;
   logic [4:0]  cfg_out_sel;
   logic        cfg_out_inv;
   logic        cfg_ready;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  x;
   logic        out_valid;
   logic        out_ready;
   logic        dut_out;
   logic        err;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   logic [17:0] prog_m [16];
   logic        co_wr    = 1'b0;
   logic [3:0]  co_addr  = 4'd0;
   logic [17:0] co_data  = 18'd0;

   maj_net_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_we_i      (cfg_we),
      .cfg_addr_i    (cfg_addr),
      .cfg_data_i    (cfg_data),
      .cfg_num_i     (cfg_num),
      .cfg_out_sel_i (cfg_out_sel),
      .cfg_out_inv_i (cfg_out_inv),
      .cfg_ready_o   (cfg_ready),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .x_i           (x),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_o         (dut_out),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [17:0] ent(input logic ia, input int sa, input logic ib,
                                       input int sb, input logic ic, input int sc);
      return {ia, 5'(sa), ib, 5'(sb), ic, 5'(sc)};
   endfunction

   // Network reference: returns {err, out}.
   function automatic logic [1:0] model(input logic [6:0] xv, input int nsat,
                                        input int osel, input logic oinv);
      logic [15:0] g;
      logic        e, v, inv;
      logic [17:0] en;
      int          sel, cnt;
      g = '0;
      e = 1'b0;
      for (int k = 0; k < nsat; k++) begin
         en  = prog_m[k];
         cnt = 0;
         for (int op = 0; op < 3; op++) begin
            sel = int'((en >> (12 - 6 * op)) & 18'h1f);
            inv = en[17 - 6 * op];
            if (sel == 0) v = 1'b0;
            else if (sel <= 7) v = xv[sel - 1];
            else if (sel - 8 < k) v = g[sel - 8];
            else begin v = 1'b0; e = 1'b1; end
            cnt += int'(v ^ inv);
         end
         g[k] = (cnt >= 2);
      end
      if (osel == 0) v = 1'b0;
      else if (osel <= 7) v = xv[osel - 1];
      else if (osel - 8 < nsat) v = g[osel - 8];
      else begin v = 1'b0; e = 1'b1; end
      return {e, v ^ oinv};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [17:0] d);
      cfg_we   = 1'b1;
      cfg_addr = 4'(a);
      cfg_data = d;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      prog_m[a] = d;
   endtask

   // One evaluation from IDLE; hold>0 keeps out_ready low that many cycles.
   task automatic run(input logic [6:0] xv, input int num, input int osel,
                      input logic oinv, input int hold, input string tag);
      logic [1:0] exp;
      int         lat, nsat;
      nsat = (num > 16) ? 16 : num;
      chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      if (co_wr) begin
         cfg_we   = 1'b1;
         cfg_addr = co_addr;
         cfg_data = co_data;
         prog_m[co_addr] = co_data;
      end
      exp = model(xv, nsat, osel, oinv);
      x           = xv;
      cfg_num     = 5'(num);
      cfg_out_sel = 5'(osel);
      cfg_out_inv = oinv;
      in_valid    = 1'b1;
      out_ready   = (hold == 0);
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      co_wr    = 1'b0;
      x        = 7'($urandom);
      lat      = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(nsat + 1));
      chk({tag, "/out"}, 32'(dut_out), 32'(exp[0]));
      chk({tag, "/err"}, 32'(err), 32'(exp[1]));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
               cfg_we   = 1'b1;
               cfg_addr = 4'd0;
               cfg_data = 18'h3ffff;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "/hold_out"}, 32'(dut_out), 32'(exp[0]));
            chk({tag, "/hold_cfg_ready"}, 32'(cfg_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int prev;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_num = '0;
      cfg_out_sel = '0; cfg_out_inv = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst/cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst/in_ready", 32'(in_ready), 32'd1);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/out", 32'(dut_out), 32'd0);
      chk("rst/err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single gate MAJ(x0,x1,x2).
      wr(0, ent(1'b0, 1, 1'b0, 2, 1'b0, 3));
      run(7'b0000011, 1, 8, 1'b0, 0, "maj_a");
      chk("maj_a/const", 32'(dut_out), 32'd1);
      run(7'b0000001, 1, 8, 1'b0, 0, "maj_b");
      wr(0, ent(1'b1, 1, 1'b0, 2, 1'b0, 3));
      run(7'b0000001, 1, 8, 1'b0, 0, "maj_inv");
      run(7'b0000110, 1, 8, 1'b0, 0, "maj_inv2");

      // Zero-gate pass-through with inversion; then an out-of-range output node.
      run(7'b0001000, 0, 4, 1'b1, 0, "num0");
      run(7'b0001000, 0, 8, 1'b0, 0, "num0_bad_sel");

      // Forward reference.
      wr(0, ent(1'b0, 9, 1'b0, 1, 1'b0, 2));
      wr(1, ent(1'b0, 8, 1'b0, 3, 1'b0, 4));
      run(7'b0000111, 2, 9, 1'b0, 0, "fwd");

      // Golden 7-gate network, all vectors back-to-back.
      wr(0, ent(1'b0, 1, 1'b0, 2, 1'b0, 3));
      wr(1, ent(1'b0, 4, 1'b0, 5, 1'b0, 6));
      wr(2, ent(1'b0, 7, 1'b0, 8, 1'b1, 9));
      wr(3, ent(1'b1, 1, 1'b0, 4, 1'b0, 10));
      wr(4, ent(1'b0, 8, 1'b0, 9, 1'b0, 0));
      wr(5, ent(1'b0, 11, 1'b0, 12, 1'b1, 7));
      wr(6, ent(1'b0, 13, 1'b0, 10, 1'b0, 2));
      prev = 0;
      for (int v = 0; v < 128; v++) begin
         run(7'(v), 7, 14, 1'b0, 0, "golden");
         if (v > 0) chk("golden/period", 32'(acc_cyc - prev), 32'd9);
         prev = acc_cyc;
      end

      // Output hold with an ignored write, then the program must be intact.
      run(7'b0101010, 7, 14, 1'b0, 5, "hold");
      run(7'b1010101, 7, 14, 1'b1, 0, "after_hold");

      // Asynchronous reset mid-evaluation.
      x = 7'h3c; cfg_num = 5'd7; cfg_out_sel = 5'd14; cfg_out_inv = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort/out_valid", 32'(out_valid), 32'd0);
      chk("abort/in_ready", 32'(in_ready), 32'd1);
      chk("abort/out", 32'(dut_out), 32'd0);
      chk("abort/err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run(7'h55, 7, 14, 1'b0, 0, "post_abort");

      // Write and accept in the same cycle: the new gate 0 is used.
      co_wr = 1'b1; co_addr = 4'd0; co_data = ent(1'b1, 0, 1'b1, 0, 1'b0, 1);
      run(7'b0000000, 1, 8, 1'b0, 0, "co_write");

      // Randomized programs, including illegal references and saturating counts.
      for (int r = 0; r < 25; r++) begin
         for (int a = 0; a < 16; a++) begin
            if (r % 2 == 0)
               wr(a, ent(1'($urandom), $urandom_range(0, 7 + a), 1'($urandom),
                         $urandom_range(0, 7 + a), 1'($urandom), $urandom_range(0, 7 + a)));
            else
               wr(a, ent(1'($urandom), $urandom_range(0, 31), 1'($urandom),
                         $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31)));
         end
         for (int t = 0; t < 3; t++) begin
            run(7'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                1'($urandom), 0, "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
